data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder_pkg.sv | 10 +
 rtl/data_memory_responder_array.sv | 29 ++
 rtl/data_memory_responder.sv | 129 ++++++++++++
 tb/tb_data_memory_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared access-size codes and boolean constants for the data memory responder.
package data_memory_responder_pkg;

  localparam logic [4:0] MEM_BYTE = 5'd0;
  localparam logic [4:0] MEM_WORD = 5'd2;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/data_memory_responder_array.sv
// Word-organised storage: synchronous byte-enabled write, combinational read.
// Single port shared by read and write; no backpressure of its own.
module dmem_array
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_idx,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding data memory responder, little-endian byte/word access with fault reporting.
// Done is high WAIT_STATES cycles after accept; ready stays low from accept until the response retires.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_in_req,
  input  logic        mem_in_memory_we2,
  input  logic [4:0]  mem_in_operation,
  input  logic [31:0] mem_in_memory_address,
  input  logic [31:0] mem_in_memory_wdata,
  output logic        dmem_out_ready,
  output logic        dmem_out_done,
  output logic [31:0] dmem_out_rdata,
  output logic        dmem_out_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_RESPOND = 2'd2;

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic [CW-1:0] r_cnt;
  logic          r_ready;
  logic          r_we;
  logic          r_word;
  logic          r_fault;
  logic [1:0]    r_lane;
  logic [AW-1:0] r_widx;
  logic [31:0]   r_wdata;

  logic          w_accept;
  logic          w_is_word;
  logic          w_is_byte;
  logic          w_fault;
  logic          w_respond;
  logic          w_wr_en;
  logic [3:0]    w_be;
  logic [31:0]   w_array_wdata;
  logic [31:0]   w_rword;
  logic [7:0]    w_rbyte;

  assign w_accept  = mem_in_req & r_ready;
  assign w_is_word = (mem_in_operation == MEM_WORD);
  assign w_is_byte = (mem_in_operation == MEM_BYTE);
  assign w_fault   = (w_is_word && (mem_in_memory_address[1:0] != 2'b00))
                  || ({2'b00, mem_in_memory_address[31:2]} >= 32'(DEPTH_WORDS))
                  || !(w_is_word || w_is_byte);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next_state = (WAIT_STATES == 0) ? S_RESPOND : S_WAIT;
      S_WAIT:    if (r_cnt == CW'(1)) w_next_state = S_RESPOND;
      S_RESPOND: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= FALSE;
    end else begin
      r_state <= w_next_state;
      r_ready <= (w_next_state == S_IDLE);
      case (r_state)
        S_IDLE:  if (w_accept) r_cnt <= CW'(WAIT_STATES);
        S_WAIT:  r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= '0;
      endcase
    end
  end

  // Request fields are frozen at accept; the inputs are don't-care afterwards.
  always_ff @(posedge clk) begin
    if (!reset && w_accept) begin
      r_we    <= mem_in_memory_we2;
      r_word  <= w_is_word;
      r_fault <= w_fault;
      r_lane  <= mem_in_memory_address[1:0];
      r_widx  <= mem_in_memory_address[AW+1:2];
      r_wdata <= mem_in_memory_wdata;
    end
  end

  assign w_respond     = (r_state == S_RESPOND);
  assign w_wr_en       = w_respond && r_we && !r_fault && !reset;
  assign w_be          = r_word ? 4'hF : (4'b0001 << r_lane);
  assign w_array_wdata = r_word ? r_wdata : {4{r_wdata[7:0]}};

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk    (clk),
    .i_we   (w_wr_en),
    .i_be   (w_be),
    .i_idx  (r_widx),
    .i_wdata(w_array_wdata),
    .o_rdata(w_rword)
  );

  always_comb begin
    w_rbyte = w_rword[7:0];
    case (r_lane)
      2'd1:    w_rbyte = w_rword[15:8];
      2'd2:    w_rbyte = w_rword[23:16];
      2'd3:    w_rbyte = w_rword[31:24];
      default: w_rbyte = w_rword[7:0];
    endcase
  end

  assign dmem_out_ready = r_ready;
  assign dmem_out_done  = w_respond;
  assign dmem_out_error = w_respond && r_fault;
  assign dmem_out_rdata = (w_respond && !r_we && !r_fault)
                        ? (r_word ? w_rword : {24'h0, w_rbyte}) : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboarded bench: expected responses are queued at accept and compared when done pulses.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  localparam int WS    = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req0, we;
  logic [4:0]  op;
  logic [31:0] addr, wdata;
  logic        ready, done, error;
  logic [31:0] rdata;
  logic        ready0, done0, error0;
  logic [31:0] rdata0;

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
    .clk(clk), .reset(reset), .mem_in_req(req), .mem_in_memory_we2(we),
    .mem_in_operation(op), .mem_in_memory_address(addr), .mem_in_memory_wdata(wdata),
    .dmem_out_ready(ready), .dmem_out_done(done), .dmem_out_rdata(rdata),
    .dmem_out_error(error)
  );

  data_memory_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_in_req(req0), .mem_in_memory_we2(we),
    .mem_in_operation(op), .mem_in_memory_address(addr), .mem_in_memory_wdata(wdata),
    .dmem_out_ready(ready0), .dmem_out_done(done0), .dmem_out_rdata(rdata0),
    .dmem_out_error(error0)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [int unsigned];
  int          errors   = 0;
  int          checks   = 0;
  int          cyc      = 0;
  int          last_acc = 0;

  task automatic model_access(input logic w, input logic [4:0] o, input logic [31:0] a,
                              input logic [31:0] d, output logic [31:0] rd, output logic er);
    int unsigned idx;
    logic [31:0] cur;
    idx = a[31:2];
    er  = (o == MEM_WORD && a[1:0] != 2'b00) || (a[31:2] >= DEPTH)
       || (o != MEM_WORD && o != MEM_BYTE);
    rd  = 32'h0;
    if (!er) begin
      cur = model.exists(idx) ? model[idx] : 32'h0;
      if (w) begin
        if (o == MEM_WORD) cur = d;
        else cur[a[1:0]*8 +: 8] = d[7:0];
        model[idx] = cur;
      end else begin
        rd = (o == MEM_WORD) ? cur : {24'h0, cur[a[1:0]*8 +: 8]};
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (reset) return;
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rdata !== e.rdata) begin
          errors++; $display("FAIL rdata %s: got %h required %h", e.name, rdata, e.rdata);
        end
        checks++;
        if (error !== e.err) begin
          errors++; $display("FAIL error %s: got %b required %b", e.name, error, e.err);
        end
        // done is consumed at the edge after this sample, so latency counts to cyc+1
        checks++;
        if (cyc + 1 - e.acc != WS + 1) begin
          errors++; $display("FAIL latency %s: got %0d required %0d", e.name, cyc + 1 - e.acc, WS + 1);
        end
        checks++;
        if (ready !== 1'b0) begin
          errors++; $display("FAIL ready_in_done %s: got %b required 0", e.name, ready);
        end
      end
    end else begin
      checks++;
      if (rdata !== 32'h0 || error !== 1'b0) begin
        errors++; $display("FAIL idle_outputs: rdata=%h error=%b required 0/0", rdata, error);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic issue(input string name, input logic w, input logic [4:0] o,
                       input logic [31:0] a, input logic [31:0] d, input bit track, input bit hold);
    exp_t e;
    logic [31:0] rd;
    logic er;
    int n;
    req = 1'b1; we = w; op = o; addr = a; wdata = d;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++; $display("FAIL accept_timeout %s: ready=%b after %0d cycles, required 1", name, ready, n);
      req = 1'b0;
      return;
    end
    if (track) begin
      model_access(w, o, a, d, rd, er);
      e.rdata = rd; e.err = er; e.acc = cyc + 1; e.name = name;
      sb.push_back(e);
    end
    step();
    last_acc = cyc;
    if (!hold) req = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain %s: %0d responses missing, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = 1'b0; req0 = 1'b0; we = 1'b0; op = MEM_WORD; addr = '0; wdata = '0;
    step(); step();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", error); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 0", rdata); end
    checks++; if (ready0 !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b required 0", ready0); end
    reset = 1'b0;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b required 1", ready); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL ready0_after_reset: got %b required 1", ready0); end
  endtask

  task automatic test_word();
    issue("st_deadbeef", 1'b1, MEM_WORD, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
    issue("ld_deadbeef", 1'b0, MEM_WORD, 32'h10, 32'h0, 1'b1, 1'b0);
    wait_drain("word");
  endtask

  task automatic test_byte();
    issue("st_11223344", 1'b1, MEM_WORD, 32'h10, 32'h11223344, 1'b1, 1'b0);
    issue("stb_ab",      1'b1, MEM_BYTE, 32'h13, 32'hFFFFFFAB, 1'b1, 1'b0);
    issue("ld_ab223344", 1'b0, MEM_WORD, 32'h10, 32'h0, 1'b1, 1'b0);
    issue("ldb_13",      1'b0, MEM_BYTE, 32'h13, 32'h0, 1'b1, 1'b0);
    issue("ldb_11",      1'b0, MEM_BYTE, 32'h11, 32'h0, 1'b1, 1'b0);
    wait_drain("byte");
  endtask

  task automatic test_fault();
    issue("st_w0",        1'b1, MEM_WORD, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
    issue("ld_misalign",  1'b0, MEM_WORD, 32'h12, 32'h0, 1'b1, 1'b0);
    issue("st_oob",       1'b1, MEM_WORD, DEPTH * 4, 32'hFFFFFFFF, 1'b1, 1'b0);
    issue("st_misalign",  1'b1, MEM_WORD, 32'h12, 32'h99999999, 1'b1, 1'b0);
    issue("st_badop",     1'b1, 5'd7,     32'h10, 32'h77777777, 1'b1, 1'b0);
    issue("ldb_oob",      1'b0, MEM_BYTE, DEPTH * 4 + 3, 32'h0, 1'b1, 1'b0);
    issue("ld_w0_after",  1'b0, MEM_WORD, 32'h0, 32'h0, 1'b1, 1'b0);
    issue("ld_w10_after", 1'b0, MEM_WORD, 32'h10, 32'h0, 1'b1, 1'b0);
    wait_drain("fault");
  endtask

  task automatic test_back_to_back();
    int acc_prev;
    int kind;
    logic [31:0] a;
    acc_prev = 0;
    for (int i = 0; i < 12; i++) begin
      a = 32'h100 + 4 * $urandom_range(0, 3);
      if (i < 4) begin
        issue("b2b_stw", 1'b1, MEM_WORD, 32'h100 + 4 * i, $urandom, 1'b1, 1'b1);
      end else begin
        kind = $urandom_range(0, 2);
        if (kind == 0)      issue("b2b_ldw", 1'b0, MEM_WORD, a, 32'h0, 1'b1, 1'b1);
        else if (kind == 1) issue("b2b_stb", 1'b1, MEM_BYTE, a + $urandom_range(0, 3), $urandom, 1'b1, 1'b1);
        else                issue("b2b_ldb", 1'b0, MEM_BYTE, a + $urandom_range(0, 3), 32'h0, 1'b1, 1'b1);
      end
      if (i > 0) begin
        checks++;
        if (last_acc - acc_prev != WS + 2) begin
          errors++; $display("FAIL b2b_spacing: got %0d required %0d", last_acc - acc_prev, WS + 2);
        end
      end
      acc_prev = last_acc;
    end
    req = 1'b0;
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    issue("st_pre20", 1'b1, MEM_WORD, 32'h20, 32'h01020304, 1'b1, 1'b0);
    wait_drain("pre20");
    issue("st_55_dropped", 1'b1, MEM_WORD, 32'h20, 32'h00000055, 1'b0, 1'b0);
    step();
    reset = 1'b1;
    step();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b required 0", done); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b required 0", ready); end
    step();
    reset = 1'b0;
    step();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready: got %b required 1", ready); end
    for (int i = 0; i < 4; i++) step();
    issue("ld_20_prior", 1'b0, MEM_WORD, 32'h20, 32'h0, 1'b1, 1'b0);
    wait_drain("reset_mid");
  endtask

  task automatic test_zero_wait();
    req0 = 1'b1; we = 1'b1; op = MEM_WORD; addr = 32'h40; wdata = 32'h0BADCAFE;
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL zw_ready: got %b required 1", ready0); end
    step();
    req0 = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL zw_store_done: got %b required 1", done0); end
    checks++; if (error0 !== 1'b0) begin errors++; $display("FAIL zw_store_error: got %b required 0", error0); end
    checks++; if (rdata0 !== 32'h0) begin errors++; $display("FAIL zw_store_rdata: got %h required 0", rdata0); end
    step();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL zw_done_clear: got %b required 0", done0); end
    checks++; if (ready0 !== 1'b1) begin errors++; $display("FAIL zw_ready_back: got %b required 1", ready0); end
    req0 = 1'b1; we = 1'b0;
    step();
    req0 = 1'b0;
    checks++; if (done0 !== 1'b1) begin errors++; $display("FAIL zw_load_done: got %b required 1", done0); end
    checks++; if (rdata0 !== 32'h0BADCAFE) begin errors++; $display("FAIL zw_load_rdata: got %h required 0badcafe", rdata0); end
    step();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL zw_load_done_clear: got %b required 0", done0); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_fault();
    test_back_to_back();
    test_reset_mid();
    test_zero_wait();
    for (int i = 0; i < 3; i++) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
